// File: rtl/etapaflops_elastic.sv
// rtl/etapaflops_elastic.sv - LANES x WIDTH elastic register pipeline with flush and beat counter
module etapaflops_elastic #(
    parameter int LANES   = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 2,
    parameter int COUNT_W = 16
) (
    input  logic                     clk_f,
    input  logic                     reset,
    input  logic [LANES*WIDTH-1:0]   data_in,
    input  logic [LANES-1:0]         valid_in,
    output logic                     in_ready,
    output logic [LANES*WIDTH-1:0]   data_out,
    output logic [LANES-1:0]         valid_out,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [COUNT_W-1:0]       beat_count
);

    localparam int DW = LANES * WIDTH;

    logic [DEPTH-1:0] occ_q, occ_d;
    logic [DEPTH-1:0] load, leave;
    logic [DEPTH-1:0] src_occ;
    logic [LANES-1:0] v_q   [DEPTH];
    logic [LANES-1:0] v_d   [DEPTH];
    logic [LANES-1:0] src_v [DEPTH];
    logic [DW-1:0]    d_q   [DEPTH];
    logic [DW-1:0]    d_d   [DEPTH];
    logic [DW-1:0]    src_d [DEPTH];
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    // Ready ripples from the output back toward the input in one cycle.
    always_comb begin
        leave = '0;
        load  = '0;
        leave[DEPTH-1] = occ_q[DEPTH-1] & out_ready;
        load[DEPTH-1]  = ~occ_q[DEPTH-1] | leave[DEPTH-1];
        for (int s = DEPTH - 2; s >= 0; s--) begin
            leave[s] = load[s+1];
            load[s]  = ~occ_q[s] | leave[s];
        end
    end

    always_comb begin
        src_occ    = '0;
        src_occ[0] = |valid_in;
        src_v[0]   = valid_in;
        src_d[0]   = data_in;
        for (int s = 1; s < DEPTH; s++) begin
            src_occ[s] = occ_q[s-1];
            src_v[s]   = v_q[s-1];
            src_d[s]   = d_q[s-1];
        end
    end

    always_comb begin
        occ_d = occ_q;
        cnt_d = cnt_q;
        for (int s = 0; s < DEPTH; s++) begin
            v_d[s] = v_q[s];
            d_d[s] = d_q[s];
        end
        if (flush) begin
            occ_d = '0;
            for (int s = 0; s < DEPTH; s++) begin
                v_d[s] = '0;
            end
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                if (load[s]) begin
                    occ_d[s] = src_occ[s];
                    v_d[s]   = src_v[s];
                    // Idle lanes keep their register contents to avoid toggling.
                    for (int k = 0; k < LANES; k++) begin
                        if (src_v[s][k]) begin
                            d_d[s][k*WIDTH +: WIDTH] = src_d[s][k*WIDTH +: WIDTH];
                        end
                    end
                end
            end
            if (occ_q[DEPTH-1] && out_ready && (cnt_q != '1)) begin
                cnt_d = cnt_q + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_f) begin
        if (reset) begin
            occ_q <= '0;
            cnt_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                v_q[s] <= '0;
                d_q[s] <= '0;
            end
        end else begin
            occ_q <= occ_d;
            cnt_q <= cnt_d;
            for (int s = 0; s < DEPTH; s++) begin
                v_q[s] <= v_d[s];
                d_q[s] <= d_d[s];
            end
        end
    end

    assign in_ready   = load[0] & ~flush;
    assign valid_out  = occ_q[DEPTH-1] ? v_q[DEPTH-1] : '0;
    assign data_out   = d_q[DEPTH-1];
    assign beat_count = cnt_q;

endmodule

// File: tb/tb_etapaflops_elastic.sv
// tb/tb_etapaflops_elastic.sv - directed bench for etapaflops_elastic at DEPTH=1 and DEPTH=2
module tb_etapaflops_elastic;

    logic        clk_f = 1'b0;
    logic        reset;

    logic [31:0] a_data;
    logic [3:0]  a_valid;
    logic        a_in_ready;
    logic [31:0] a_data_out;
    logic [3:0]  a_valid_out;
    logic        a_out_ready;
    logic        a_flush;
    logic [3:0]  a_count;

    logic [31:0] b_data;
    logic [3:0]  b_valid;
    logic        b_in_ready;
    logic [31:0] b_data_out;
    logic [3:0]  b_valid_out;
    logic        b_out_ready;
    logic        b_flush;
    logic [15:0] b_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_f = ~clk_f;

    etapaflops_elastic #(.LANES(4), .WIDTH(8), .DEPTH(1), .COUNT_W(4)) u_a (
        .clk_f(clk_f), .reset(reset),
        .data_in(a_data), .valid_in(a_valid), .in_ready(a_in_ready),
        .data_out(a_data_out), .valid_out(a_valid_out), .out_ready(a_out_ready),
        .flush(a_flush), .beat_count(a_count)
    );

    etapaflops_elastic #(.LANES(4), .WIDTH(8), .DEPTH(2), .COUNT_W(16)) u_b (
        .clk_f(clk_f), .reset(reset),
        .data_in(b_data), .valid_in(b_valid), .in_ready(b_in_ready),
        .data_out(b_data_out), .valid_out(b_valid_out), .out_ready(b_out_ready),
        .flush(b_flush), .beat_count(b_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_f);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_data = '0; a_valid = '0; a_out_ready = 1'b0; a_flush = 1'b0;
        b_data = '0; b_valid = '0; b_out_ready = 1'b0; b_flush = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_a_valid", a_valid_out, 4'h0);
        chk("rst_a_data",  a_data_out,  32'h0);
        chk("rst_a_count", a_count,     4'h0);
        chk("rst_a_ready", a_in_ready,  1'b1);
        chk("rst_b_valid", b_valid_out, 4'h0);
        chk("rst_b_data",  b_data_out,  32'h0);
        chk("rst_b_count", b_count,     16'h0);
        chk("rst_b_ready", b_in_ready,  1'b1);

        // DEPTH=1 streaming
        a_out_ready = 1'b1; a_valid = 4'hF; a_data = 32'h04030201;
        step();
        chk("d1_b1_valid", a_valid_out, 4'hF);
        chk("d1_b1_data",  a_data_out,  32'h04030201);
        chk("d1_b1_count", a_count,     4'd0);
        a_data = 32'h08070605;
        step();
        chk("d1_b2_valid", a_valid_out, 4'hF);
        chk("d1_b2_data",  a_data_out,  32'h08070605);
        chk("d1_b2_count", a_count,     4'd1);
        a_valid = 4'h0; a_data = 32'hDEADBEEF;
        step();
        chk("d1_bub_valid", a_valid_out, 4'h0);
        chk("d1_bub_data",  a_data_out,  32'h08070605);
        chk("d1_bub_count", a_count,     4'd2);

        // DEPTH=1 saturation with COUNT_W=4
        a_valid = 4'hF;
        for (int i = 1; i <= 20; i++) begin
            a_data = 32'(i);
            step();
            if (i == 10) chk("sat_mid_count", a_count, 4'd11);
        end
        chk("sat_last_data", a_data_out, 32'd20);
        a_valid = 4'h0;
        step();
        chk("sat_final_count", a_count, 4'd15);

        // DEPTH=2 single-lane beat
        b_out_ready = 1'b1; b_valid = 4'b0001; b_data = 32'h000000AA;
        step();
        chk("d2_one_early", b_valid_out, 4'h0);
        b_valid = 4'h0; b_data = 32'hFFFFFFFF;
        step();
        chk("d2_one_valid", b_valid_out, 4'b0001);
        chk("d2_one_data",  b_data_out,  32'h000000AA);
        step();
        chk("d2_one_gone",  b_valid_out, 4'h0);
        chk("d2_one_hold",  b_data_out,  32'h000000AA);
        chk("d2_one_count", b_count,     16'd1);

        // DEPTH=2 stall, fill, release
        b_out_ready = 1'b0; b_valid = 4'hF; b_data = 32'h11111111;
        #1;
        chk("stall_rdy0", b_in_ready, 1'b1);
        step();
        b_data = 32'h22222222;
        #1;
        chk("stall_rdy1", b_in_ready, 1'b1);
        step();
        chk("stall_out1", b_data_out, 32'h11111111);
        b_data = 32'h33333333;
        #1;
        chk("stall_full_rdy", b_in_ready, 1'b0);
        step();
        chk("stall_hold_valid", b_valid_out, 4'hF);
        chk("stall_hold_data",  b_data_out,  32'h11111111);
        chk("stall_hold_rdy",   b_in_ready,  1'b0);
        b_out_ready = 1'b1;
        #1;
        chk("full_release_rdy", b_in_ready, 1'b1);
        step();
        chk("rel_b2_data",  b_data_out, 32'h22222222);
        chk("rel_b2_count", b_count,    16'd2);
        b_valid = 4'h0;
        step();
        chk("rel_b3_data",  b_data_out,  32'h33333333);
        chk("rel_b3_valid", b_valid_out, 4'hF);
        chk("rel_b3_count", b_count,     16'd3);
        step();
        chk("rel_end_valid", b_valid_out, 4'h0);
        chk("rel_end_count", b_count,     16'd4);

        // DEPTH=2 flush of a full pipeline
        b_out_ready = 1'b0; b_valid = 4'hF; b_data = 32'hA1A1A1A1;
        step();
        b_data = 32'hB2B2B2B2;
        step();
        chk("fl_pre_data", b_data_out, 32'hA1A1A1A1);
        b_flush = 1'b1; b_data = 32'hC3C3C3C3;
        #1;
        chk("fl_rdy", b_in_ready, 1'b0);
        step();
        chk("fl_valid", b_valid_out, 4'h0);
        chk("fl_data_hold", b_data_out, 32'hA1A1A1A1);
        chk("fl_count", b_count, 16'd4);
        b_flush = 1'b0; b_valid = 4'h0; b_out_ready = 1'b1;
        step();
        step();
        chk("fl_after_valid", b_valid_out, 4'h0);
        chk("fl_after_count", b_count,     16'd4);
        chk("fl_after_rdy",   b_in_ready,  1'b1);

        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("rst2_b_count", b_count,    16'd0);
        chk("rst2_b_data",  b_data_out, 32'h0);
        chk("rst2_a_count", a_count,    4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/etapaflops_elastic.md
# etapaflops_elastic

Parametrised successor of the fixed four-lane, 8-bit PHY register stage. Registers LANES parallel byte lanes, each with its own valid bit, through DEPTH elastic pipeline stages with ready/valid backpressure, a synchronous flush and a saturating beat counter. Sits between the PHY lane logic and downstream consumers that may stall.

## Interface
- LANES, default 4: number of parallel lanes (≥1).
- WIDTH, default 8: bits per lane (≥1).
- DEPTH, default 2: number of pipeline stages (≥1).
- COUNT_W, default 16: width of the delivered-beat counter.
- clk_f  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- valid_in  in  LANES  per-lane valid; bit k qualifies lane k.
- in_ready  out  1  stage can accept a beat this cycle.
- data_out  out  LANES*WIDTH  last-stage lane data.
- valid_out  out  LANES  last-stage lane valids; all-zero when the last stage is empty.
- out_ready  in  1  consumer accepts the beat on data_out/valid_out.
- flush  in  1  synchronous discard of all held beats.
- beat_count  out  COUNT_W  saturating count of delivered beats.

## Operation
- Beat: the set of LANES lanes presented together. Input beat is offered when |valid_in = 1. A cycle with valid_in = 0 is a bubble and is never stored.
- Each stage s (0 = input, DEPTH-1 = output) has an occupied flag occ[s], a lane-valid vector v[s] and LANES data registers d[s].
- Advance rule: stage s loads when it is empty or when its contents leave this cycle. Stage DEPTH-1 contents leave when occ[DEPTH-1] & out_ready. Stage s<DEPTH-1 contents leave when stage s+1 loads.
- in_ready = !occ[0] | (stage 0 contents leave this cycle); combinational, may depend on out_ready. Accept = in_ready & |valid_in & !flush.
- On load, v[s] takes the upstream valid vector. Lane data register d[s][k] loads only when the incoming lane-valid bit k is 1; otherwise it holds its previous value (no toggling on idle lanes).
- An empty stage that does not load keeps d[s] and clears v[s].
- valid_out = v[DEPTH-1] when occ[DEPTH-1], else 0. data_out = d[DEPTH-1] unconditionally; contents are meaningful only on lanes with valid_out bit set.
- Delivery = occ[DEPTH-1] & out_ready & !flush. beat_count increments by 1 per delivery and saturates at 2^COUNT_W−1.
- flush: at the edge, all occ and v bits clear; d registers hold; beat_count is unaffected; in_ready is 0 in a flush cycle; no beat is accepted or delivered in that cycle.
- reset: dominates flush; all occ, v and d registers clear to 0, and beat_count clears to 0.
- Beat ordering is strictly preserved. Beats are never dropped or duplicated except when discarded by flush or reset.

## Timing
- Reset values: data_out = 0, valid_out = 0, beat_count = 0. in_ready = 1 in the first cycle after reset deasserts, or 0 if flush is high in that cycle.
- Latency: a beat accepted at edge t is on valid_out/data_out after edge t+DEPTH−1, provided there is no stall, i.e. DEPTH cycles from presentation. With DEPTH=1 and out_ready held at 1, the output is the input delayed one cycle, with bubbles shown as valid_out = 0.
- Throughput: one beat per cycle while out_ready = 1. Interior bubbles collapse under stall.
- Full: all DEPTH stages occupied and out_ready = 0 gives in_ready = 0. A simultaneous out_ready = 1 raises in_ready in the same cycle.
- Simultaneous accept and deliver with a full pipeline: both occur and occupancy is unchanged.
- Reset or flush mid-stall: all held beats are lost. The next edge after deassertion behaves as empty.

## Test plan
- LANES=4, WIDTH=8, DEPTH=1, out_ready=1, stream data_in 0x04030201, 0x08070605 with valid_in=4'hF -> the same words appear one cycle later with valid_out=4'hF; beat_count reaches 2.
- DEPTH=2, single beat 0x000000AA with valid_in=4'b0001, then idle -> valid_out=4'b0001 exactly once, after 2 edges; data_out lanes 1–3 keep their prior values (0 after reset).
- DEPTH=2, hold out_ready=0 and offer 3 beats -> first 2 accepted; in_ready=0 from the cycle after the second accept. Raise out_ready -> beats emerge in order, one per cycle, and the third is then accepted.
- Full pipeline with out_ready=1 and a new beat offered in the same cycle -> in_ready=1; occupancy unchanged; no beat lost.
- Full pipeline, assert flush for 1 cycle -> valid_out=0 next cycle; held beats never appear; beat_count unchanged; reset then clears beat_count to 0.
- COUNT_W=4, deliver 20 beats -> beat_count saturates at 15.
